clap_controller: RTL and testbench
==================================

# clap_controller

Sequencing controller for the clapper datapath: qualifies clap events from the rectified microphone/filter magnitude stream, groups them into clap patterns within a timing window, and drives a toggled output. Sits downstream of the sample-magnitude path, in the CLOCK_50 domain, and replaces the ad-hoc counting logic that feeds the green-LED display.

## Interface
- DATA_WIDTH, 16, magnitude sample width
- HOLD_CYCLES, 5_000_000, refractory period after a clap: 100 ms at 50 MHz
- WINDOW_CYCLES, 50_000_000, maximum gap between claps in one pattern: 1 s
- MAX_CLAPS, 15, saturation value of the clap counter; must fit in 4 bits
- AUTO_OFF_CYCLES, 500_000_000, auto-off timeout; used only with CLAP_AUTO_OFF_EN
- clk  in  1  system clock (CLOCK_50)
- rst  in  1  asynchronous, active-low reset
- enable  in  1  controller enable; low forces IDLE
- sample_valid  in  1  one-cycle strobe qualifying sample_abs
- sample_abs  in  DATA_WIDTH  unsigned sample magnitude
- threshold  in  DATA_WIDTH  clap detection level; sampled when each strobe is accepted
- clap_pulse  out  1  one-cycle pulse per qualified clap
- clap_count  out  4  number of claps in the current pattern
- pattern_valid  out  1  one-cycle pulse when a pattern closes
- pattern_count  out  4  clap count of the last closed pattern; held until the next one
- light_on  out  1  toggled output
- state  out  2  current FSM state: IDLE=0, ARMED=1, HOLD=2, GAP=3

## Operation
- IDLE: clap_count=0. Go to ARMED when enable=1.
- ARMED, first clap: a clap is sample_valid=1 with sample_abs > threshold (strict).
  - Pulse clap_pulse.
  - Set clap_count=1.
  - Load the hold timer with HOLD_CYCLES−1 and go to HOLD.
- HOLD: decrement the hold timer every cycle.
  - Exit requires timer==0 and at least one valid sample with sample_abs < (threshold>>1) seen since entering HOLD. This is the hysteresis condition.
  - On exit, load the window timer with WINDOW_CYCLES−1 and go to GAP.
- GAP: decrement the window timer every cycle.
  - A clap increments clap_count (saturates at MAX_CLAPS), pulses clap_pulse, reloads the hold timer and returns to HOLD.
  - When the window timer reaches 0 with no clap that cycle, the pattern closes:
    - pattern_valid=1 for one cycle.
    - pattern_count = clap_count.
    - clap_count cleared.
    - Next state is ARMED.
- Clap in the same cycle as window expiry: the clap wins and no pattern closes.
- Action on pattern close: pattern_count==2 toggles light_on; pattern_count==3 forces light_on=0. Other counts have no action.
- Window timer counts only in GAP and hold timer counts only in HOLD, so the window period starts at the end of HOLD.
- enable deasserted in any state: next cycle is IDLE, clap_count=0, timers cleared, no pattern_valid. light_on and pattern_count are retained.
- Samples are ignored whenever sample_valid=0. The HOLD timers still run.

## Timing
- Reset values: state=IDLE, clap_count=0, pattern_count=0, clap_pulse=0, pattern_valid=0, light_on=0, all timers 0.
- All outputs are registered.
- Clap latency: clap_pulse is asserted the cycle after the qualifying strobe. clap_count updates on the same edge.
- Pattern close: pattern_valid, pattern_count and light_on update on the same edge, one cycle after the window timer reads 0.
- Minimum clap-to-clap spacing is HOLD_CYCLES+1 cycles.
- Reset asserted mid-pattern: immediate return to reset values, including light_on.

## Configuration
- CLAP_AUTO_OFF_EN defined:
  - A 29-bit (or wider) auto-off timer reloads with AUTO_OFF_CYCLES−1 on every light_on 0→1 transition and on every pattern_valid.
  - It decrements while light_on=1.
  - At 0 it clears light_on, with no pattern_valid.
  - The timer is reset to 0.
- CLAP_AUTO_OFF_EN undefined: the timer logic is absent and light_on changes only on pattern close or reset.

## Test plan
Bench parameters: HOLD_CYCLES=8, WINDOW_CYCLES=64, threshold=1000, one strobe every 4 cycles.
- Two claps: sample_abs=2000, then quiet 100 for 12 cycles, 2000 again, then quiet → 2 clap_pulse, then pattern_valid with pattern_count=2 and light_on 0→1. Repeat → light_on 1→0.
- Three claps, then later a single clap → pattern_count=3 forces light_on=0. The single clap gives pattern_count=1 with light_on unchanged.
- Loud sustained sample 2000 for 40 cycles → exactly one clap_pulse. HOLD persists until a sample below 500 arrives.
- Sample equal to 1000 → no clap. Sample of 1001 → clap.
- 20 claps spaced 16 cycles apart → clap_count saturates at 15 and pattern_count=15.
- enable dropped in GAP with clap_count=2 → state=IDLE next cycle, no pattern_valid, light_on unchanged. Reset (rst=0) mid-HOLD → all outputs zero asynchronously.
- With CLAP_AUTO_OFF_EN and AUTO_OFF_CYCLES=200: light_on turned on by a 2-clap pattern clears 200 cycles after that pattern_valid.

Source files
------------

// File: rtl/clap_controller.sv
// Clap controller: qualifies claps from a magnitude stream, groups them into timed patterns and
// toggles light_on. Define CLAP_AUTO_OFF_EN to add an auto-off timer for light_on.
module clap_controller #(
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned HOLD_CYCLES     = 5_000_000,
    parameter int unsigned WINDOW_CYCLES   = 50_000_000,
    parameter int unsigned MAX_CLAPS       = 15,
    parameter int unsigned AUTO_OFF_CYCLES = 500_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] sample_abs,
    input  logic [DATA_WIDTH-1:0] threshold,
    output logic                  clap_pulse,
    output logic [3:0]            clap_count,
    output logic                  pattern_valid,
    output logic [3:0]            pattern_count,
    output logic                  light_on,
    output logic [1:0]            state
);

    localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned WinW  = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_CYCLES - 1);
    localparam logic [WinW-1:0]  WinLoad  = WinW'(WINDOW_CYCLES - 1);
    localparam logic [3:0]       MaxClaps = 4'(MAX_CLAPS);

    if (MAX_CLAPS == 0 || MAX_CLAPS > 15 || HOLD_CYCLES == 0 || WINDOW_CYCLES == 0 ||
        AUTO_OFF_CYCLES == 0) begin : g_param_check
        $error("clap_controller: invalid parameter value");
    end

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StHold  = 2'd2,
        StGap   = 2'd3
    } state_e;

    state_e           state_q;
    logic [HoldW-1:0] hold_q;
    logic [WinW-1:0]  win_q;
    logic             quiet_q;   // a below-hysteresis sample has been seen in this HOLD
    logic             clap;
    logic             quiet;
    logic             close_now;

    assign clap      = sample_valid && (sample_abs > threshold);
    assign quiet     = sample_valid && (sample_abs < (threshold >> 1));
    assign close_now = enable && (state_q == StGap) && !clap && (win_q == '0);
    assign state     = state_q;

`ifdef CLAP_AUTO_OFF_EN
    localparam int unsigned AutoW = ($clog2(AUTO_OFF_CYCLES) > 29) ? $clog2(AUTO_OFF_CYCLES) : 29;
    localparam logic [AutoW-1:0] AutoLoad = AutoW'(AUTO_OFF_CYCLES - 1);
    logic [AutoW-1:0] auto_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            hold_q        <= '0;
            win_q         <= '0;
            quiet_q       <= 1'b0;
            clap_count    <= '0;
            pattern_count <= '0;
            clap_pulse    <= 1'b0;
            pattern_valid <= 1'b0;
            light_on      <= 1'b0;
`ifdef CLAP_AUTO_OFF_EN
            auto_q        <= '0;
`endif
        end else begin
            clap_pulse    <= 1'b0;
            pattern_valid <= 1'b0;
`ifdef CLAP_AUTO_OFF_EN
            // Every pattern close re-arms the timer, which covers every 0->1 of light_on.
            if (close_now) begin
                auto_q <= AutoLoad;
            end else if (light_on) begin
                if (auto_q == '0) begin
                    light_on <= 1'b0;
                end else begin
                    auto_q <= auto_q - AutoW'(1);
                end
            end
`endif
            if (!enable) begin
                state_q    <= StIdle;
                clap_count <= '0;
                hold_q     <= '0;
                win_q      <= '0;
                quiet_q    <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        clap_count <= '0;
                        state_q    <= StArmed;
                    end
                    StArmed: begin
                        if (clap) begin
                            clap_pulse <= 1'b1;
                            clap_count <= 4'd1;
                            hold_q     <= HoldLoad;
                            quiet_q    <= 1'b0;
                            state_q    <= StHold;
                        end
                    end
                    StHold: begin
                        if (quiet) begin
                            quiet_q <= 1'b1;
                        end
                        if (hold_q != '0) begin
                            hold_q <= hold_q - HoldW'(1);
                        end else if (quiet_q || quiet) begin
                            win_q   <= WinLoad;
                            state_q <= StGap;
                        end
                    end
                    StGap: begin
                        // A clap on the expiry cycle extends the pattern instead of closing it.
                        if (clap) begin
                            clap_pulse <= 1'b1;
                            if (clap_count != MaxClaps) begin
                                clap_count <= clap_count + 4'd1;
                            end
                            hold_q  <= HoldLoad;
                            win_q   <= '0;
                            quiet_q <= 1'b0;
                            state_q <= StHold;
                        end else if (close_now) begin
                            pattern_valid <= 1'b1;
                            pattern_count <= clap_count;
                            clap_count    <= '0;
                            state_q       <= StArmed;
                            if (clap_count == 4'd2) begin
                                light_on <= ~light_on;
                            end else if (clap_count == 4'd3) begin
                                light_on <= 1'b0;
                            end
                        end else begin
                            win_q <= win_q - WinW'(1);
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clap_controller.sv
// Directed bench for clap_controller with short timers (HOLD=8, WINDOW=64, AUTO_OFF=200).
// Covers the auto-off path when CLAP_AUTO_OFF_EN is defined.
module tb_clap_controller;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        sample_valid;
    logic [15:0] sample_abs;
    logic [15:0] threshold;
    logic        clap_pulse;
    logic [3:0]  clap_count;
    logic        pattern_valid;
    logic [3:0]  pattern_count;
    logic        light_on;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int pv_cnt = 0;

    clap_controller #(
        .DATA_WIDTH     (16),
        .HOLD_CYCLES    (8),
        .WINDOW_CYCLES  (64),
        .MAX_CLAPS      (15),
        .AUTO_OFF_CYCLES(200)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .sample_valid (sample_valid),
        .sample_abs   (sample_abs),
        .threshold    (threshold),
        .clap_pulse   (clap_pulse),
        .clap_count   (clap_count),
        .pattern_valid(pattern_valid),
        .pattern_count(pattern_count),
        .light_on     (light_on),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (clap_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;
        if (pattern_valid === 1'b1) pv_cnt <= pv_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic strobe(input logic [15:0] v);
        sample_valid = 1'b1;
        sample_abs   = v;
        tick();
        sample_valid = 1'b0;
    endtask

    // One clap followed by 12 quiet cycles (3 quiet strobes): next clap lands 16 cycles later.
    task automatic clap_seq(input logic [15:0] v, input int exp_count);
        strobe(v);
        check("clap_pulse", clap_pulse, 1);
        check("clap_count", clap_count, exp_count);
        check("state_hold", state, 2);
        idle(3);
        repeat (3) begin
            strobe(16'd100);
            idle(3);
        end
    endtask

    task automatic finish_pattern(input int exp_pc, input logic exp_light, input int exp_lat);
        int n = 0;
        while (pattern_valid !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check("close_latency", n, exp_lat);
        check("pattern_valid", pattern_valid, 1);
        check("pattern_count", pattern_count, exp_pc);
        check("light_on", light_on, exp_light);
        check("clap_count_clr", clap_count, 0);
        check("state_armed", state, 1);
        tick();
        check("pattern_valid_1cyc", pattern_valid, 0);
    endtask

    task automatic pattern(input int n, input logic exp_light);
        int p0 = pulse_cnt;
        for (int i = 1; i <= n; i++) clap_seq(16'd2000, (i > 15) ? 15 : i);
        check("pulse_total", pulse_cnt - p0, n);
        finish_pattern((n > 15) ? 15 : n, exp_light, 57);
    endtask

    initial begin
        int p0;
        int v0;
        rst          = 1'b1;
        enable       = 1'b0;
        sample_valid = 1'b0;
        sample_abs   = '0;
        threshold    = 16'd1000;
        #1 rst = 1'b0;
        #2;
        check("rst_state", state, 0);
        check("rst_clap_count", clap_count, 0);
        check("rst_pattern_count", pattern_count, 0);
        check("rst_clap_pulse", clap_pulse, 0);
        check("rst_pattern_valid", pattern_valid, 0);
        check("rst_light_on", light_on, 0);
        idle(2);
        rst    = 1'b1;
        enable = 1'b1;
        tick();
        check("armed", state, 1);

        // Toggle, toggle, toggle, forced off, toggle, single clap (no action)
        pattern(2, 1'b1);
        pattern(2, 1'b0);
        pattern(2, 1'b1);
        pattern(3, 1'b0);
        pattern(2, 1'b1);
        pattern(1, 1'b1);

        // Threshold is a strict comparison
        strobe(16'd1000);
        check("eq_thresh_no_pulse", clap_pulse, 0);
        check("eq_thresh_state", state, 1);
        idle(3);
        clap_seq(16'd1001, 1);
        finish_pattern(1, 1'b1, 57);

        // Sustained loud input: one clap, HOLD until a quiet sample appears
        p0 = pulse_cnt;
        repeat (10) begin
            strobe(16'd2000);
            idle(3);
        end
        check("loud_one_pulse", pulse_cnt - p0, 1);
        check("loud_still_hold", state, 2);
        strobe(16'd100);
        check("loud_to_gap", state, 3);
        finish_pattern(1, 1'b1, 64);

        pattern(2, 1'b0);
        pattern(20, 1'b0);
        pattern(2, 1'b1);

        // Enable dropped in GAP with two claps counted
        clap_seq(16'd2000, 1);
        clap_seq(16'd2000, 2);
        check("gap_before_disable", state, 3);
        v0 = pv_cnt;
        enable = 1'b0;
        tick();
        check("dis_state", state, 0);
        check("dis_clap_count", clap_count, 0);
        check("dis_pattern_valid", pattern_valid, 0);
        check("dis_light_kept", light_on, 1);
        check("dis_pc_kept", pattern_count, 2);
        idle(80);
        check("dis_no_close", pv_cnt - v0, 0);
        check("dis_idle", state, 0);
        enable = 1'b1;
        tick();
        check("reenable", state, 1);

        // Asynchronous reset in HOLD, right after the clap pulse
        strobe(16'd2000);
        check("pre_rst_hold", state, 2);
        check("pre_rst_pulse", clap_pulse, 1);
        rst = 1'b0;
        #2;
        check("arst_state", state, 0);
        check("arst_clap_count", clap_count, 0);
        check("arst_pattern_count", pattern_count, 0);
        check("arst_clap_pulse", clap_pulse, 0);
        check("arst_light_on", light_on, 0);
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_armed", state, 1);

`ifdef CLAP_AUTO_OFF_EN
        pattern(2, 1'b1);
        v0 = pv_cnt;
        idle(198);
        check("auto_off_before", light_on, 1);
        tick();
        check("auto_off_at", light_on, 0);
        check("auto_off_no_pv", pv_cnt - v0, 0);
`else
        pattern(2, 1'b1);
        idle(300);
        check("light_held", light_on, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
